// File: rtl/ampel_phasen_steuerung_if.sv
// Signal bundle between the traffic-light phase sequencer and its environment.
// The controller side drives enable/knopf; the sequencer drives the phase outputs.
interface ampel_phasen_steuerung_if;
  logic       enable;
  logic       knopf;
  logic [2:0] counter;
  logic       step_strobe;
  logic       red_hold;
  logic       request_pending;

  modport master (
    output enable,
    output knopf,
    input  counter,
    input  step_strobe,
    input  red_hold,
    input  request_pending
  );

  modport slave (
    input  enable,
    input  knopf,
    output counter,
    output step_strobe,
    output red_hold,
    output request_pending
  );
endinterface

// File: rtl/ampel_phasen_steuerung.sv
// Traffic-light phase sequencer: prescaled 3-bit phase counter with a debounced
// pedestrian request that stretches the red phase (counter = 7) by extra steps.
module ampel_phasen_steuerung #(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned EXTEND_STEPS = 3
) (
  input logic                        clk,
  input logic                        rst,
  ampel_phasen_steuerung_if.slave    bus_io
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned HW = $clog2(EXTEND_STEPS + 1);

  localparam logic [PW-1:0] PresMax  = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DebMax   = DW'(DEBOUNCE);
  localparam logic [HW-1:0] HoldInit = HW'(EXTEND_STEPS);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic          knopf_meta_q, knopf_s_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_lvl, deb_lvl_q;
  logic          press;

  logic [0:0]    state_q, state_d;
  logic [2:0]    counter_q, counter_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          red_q, red_d;
  logic          pend_q, pend_d;
  logic          strobe_q;

  // Prescaler holds its value while disabled so re-enable resumes mid-step.
  always_comb begin
    tick    = bus_io.enable && (presc_q == PresMax);
    presc_d = presc_q;
    if (bus_io.enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!knopf_s_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DebMax) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    deb_lvl = (deb_cnt_q == DebMax);
    press   = deb_lvl && !deb_lvl_q;
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    hold_d    = hold_q;
    red_d     = red_q;
    pend_d    = pend_q;
    // Presses seen while holding (including the exit cycle) are discarded.
    if (press && (state_q != StHold)) begin
      pend_d = 1'b1;
    end
    if (tick) begin
      case (state_q)
        StRun: begin
          if ((counter_q == 3'd7) && pend_q) begin
            state_d = StHold;
            hold_d  = HoldInit;
            red_d   = 1'b1;
            pend_d  = 1'b0;
          end else begin
            counter_d = counter_q + 3'd1;
          end
        end
        StHold: begin
          hold_d = hold_q - 1'b1;
          if (hold_q == HW'(1)) begin
            counter_d = 3'd0;
            red_d     = 1'b0;
            state_d   = StRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      knopf_meta_q <= 1'b0;
      knopf_s_q    <= 1'b0;
      deb_cnt_q    <= '0;
      deb_lvl_q    <= 1'b0;
      state_q      <= StRun;
      counter_q    <= 3'd0;
      hold_q       <= '0;
      red_q        <= 1'b0;
      pend_q       <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      knopf_meta_q <= bus_io.knopf;
      knopf_s_q    <= knopf_meta_q;
      deb_cnt_q    <= deb_cnt_d;
      deb_lvl_q    <= deb_lvl;
      state_q      <= state_d;
      counter_q    <= counter_d;
      hold_q       <= hold_d;
      red_q        <= red_d;
      pend_q       <= pend_d;
      strobe_q     <= tick;
    end
  end

  assign bus_io.counter         = counter_q;
  assign bus_io.step_strobe     = strobe_q;
  assign bus_io.red_hold        = red_q;
  assign bus_io.request_pending = pend_q;

endmodule

// File: tb/tb_ampel_phasen_steuerung.sv
// Directed bench for the phase sequencer (CLK_DIV=4, DEBOUNCE=3, EXTEND_STEPS=2).
// Inputs change and outputs are sampled on the falling edge; e counts rising edges since reset release.
module tb_ampel_phasen_steuerung;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   e;
  int   strobes;
  logic any_red;
  logic any_pend;

  ampel_phasen_steuerung_if bus ();

  ampel_phasen_steuerung #(
    .CLK_DIV      (4),
    .DEBOUNCE     (3),
    .EXTEND_STEPS (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic goto(input int t);
    while (e < t) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic s, input logic r,
                         input logic p);
    chk({tag, ".counter"}, 32'(bus.counter), 32'(c));
    chk({tag, ".strobe"}, 32'(bus.step_strobe), 32'(s));
    chk({tag, ".red_hold"}, 32'(bus.red_hold), 32'(r));
    chk({tag, ".pending"}, 32'(bus.request_pending), 32'(p));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    e          = 0;
    strobes    = 0;
    any_red    = 1'b0;
    any_pend   = 1'b0;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.knopf  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    rst        = 1'b0;
    bus.enable = 1'b1;
    e          = 0;

    // Free-running sequence: one step every 4 cycles
    for (int k = 1; k <= 40; k++) begin
      goto(k);
      chk("run.counter", 32'(bus.counter), 32'((k / 4) % 8));
      chk("run.strobe", 32'(bus.step_strobe), 32'(k % 4 == 0));
      if (bus.step_strobe) strobes++;
      any_red  = any_red | bus.red_hold;
      any_pend = any_pend | bus.request_pending;
    end
    chk("run.strobe_count", 32'(strobes), 32'd10);
    chk("run.no_red", 32'(any_red), 32'd0);
    chk("run.no_pending", 32'(any_pend), 32'd0);

    // Accepted press, served at the next counter = 7
    bus.knopf = 1'b1;
    goto(45);
    chk("press.pending_pre", 32'(bus.request_pending), 32'd0);
    goto(46);
    chk("press.pending_set", 32'(bus.request_pending), 32'd1);
    goto(48);
    bus.knopf = 1'b0;
    goto(59);
    chk_all("press.e59", 3'd6, 1'b0, 1'b0, 1'b1);
    goto(60);
    chk_all("press.e60", 3'd7, 1'b1, 1'b0, 1'b1);
    goto(63);
    chk_all("press.e63", 3'd7, 1'b0, 1'b0, 1'b1);
    goto(64);
    chk_all("hold.enter", 3'd7, 1'b1, 1'b1, 1'b0);
    goto(68);
    chk_all("hold.mid", 3'd7, 1'b1, 1'b1, 1'b0);
    goto(71);
    chk_all("hold.last", 3'd7, 1'b0, 1'b1, 1'b0);
    goto(72);
    chk_all("hold.exit", 3'd0, 1'b1, 1'b0, 1'b0);

    // Glitch shorter than the debounce window
    bus.knopf = 1'b1;
    goto(74);
    bus.knopf = 1'b0;
    goto(80);
    chk("glitch.pending", 32'(bus.request_pending), 32'd0);
    goto(103);
    chk_all("glitch.e103", 3'd7, 1'b0, 1'b0, 1'b0);
    goto(104);
    chk_all("glitch.wrap", 3'd0, 1'b1, 1'b0, 1'b0);

    // Press accepted while holding is dropped
    bus.knopf = 1'b1;
    goto(110);
    chk("drop.pending_set", 32'(bus.request_pending), 32'd1);
    goto(112);
    bus.knopf = 1'b0;
    goto(136);
    chk_all("drop.enter", 3'd7, 1'b1, 1'b1, 1'b0);
    bus.knopf = 1'b1;
    goto(142);
    chk_all("drop.e142", 3'd7, 1'b0, 1'b1, 1'b0);
    goto(143);
    chk("drop.e143.pending", 32'(bus.request_pending), 32'd0);
    goto(144);
    chk_all("drop.exit", 3'd0, 1'b1, 1'b0, 1'b0);
    bus.knopf = 1'b0;
    goto(172);
    chk_all("drop.e172", 3'd7, 1'b1, 1'b0, 1'b0);
    goto(176);
    chk_all("drop.plain_wrap", 3'd0, 1'b1, 1'b0, 1'b0);

    // Enable freeze with prescaler at 2
    goto(190);
    chk_all("freeze.pre", 3'd3, 1'b0, 1'b0, 1'b0);
    bus.enable = 1'b0;
    for (int k = 191; k <= 210; k++) begin
      goto(k);
      chk("freeze.counter", 32'(bus.counter), 32'd3);
      chk("freeze.strobe", 32'(bus.step_strobe), 32'd0);
    end
    bus.enable = 1'b1;
    goto(211);
    chk_all("resume.e211", 3'd3, 1'b0, 1'b0, 1'b0);
    goto(212);
    chk_all("resume.e212", 3'd4, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a hold
    bus.knopf = 1'b1;
    goto(218);
    chk("rsthold.pending", 32'(bus.request_pending), 32'd1);
    goto(220);
    bus.knopf = 1'b0;
    goto(224);
    chk_all("rsthold.e224", 3'd7, 1'b1, 1'b0, 1'b1);
    goto(228);
    chk_all("rsthold.enter", 3'd7, 1'b1, 1'b1, 1'b0);
    goto(230);
    chk_all("rsthold.e230", 3'd7, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("rsthold.async", 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_all("rsthold.held", 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    e   = 0;
    goto(4);
    chk_all("after.e4", 3'd1, 1'b1, 1'b0, 1'b0);
    goto(28);
    chk_all("after.e28", 3'd7, 1'b1, 1'b0, 1'b0);
    goto(32);
    chk_all("after.wrap", 3'd0, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
